// File: rtl/ifetch_pkg.sv
// ------------------------------------------------------------------
// ifetch_pkg: opcodes, reset address and queue entry type for ifetch.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package ifetch_pkg;

  localparam logic [6:0]  OPC_JAL          = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned IRamSize         = 4096;

  typedef struct packed {
    logic        pred;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_if.sv
// ------------------------------------------------------------------
// ifetch_if: instruction RAM port plus decode handshake of ifetch.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface ifetch_if;

  logic [31:0] pc_n_o;
  logic        iram_rd_o;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;
  logic        id_pred_o;

  modport master (
    output pc_n_o, iram_rd_o, id_valid_o, id_inst_o, id_pc_o, id_pred_o,
    input  pc_i, inst_i, id_ready_i
  );

  modport slave (
    input  pc_n_o, iram_rd_o, id_valid_o, id_inst_o, id_pc_o, id_pred_o,
    output pc_i, inst_i, id_ready_i
  );

endinterface

`default_nettype wire

// File: rtl/ifetch_buf.sv
// ------------------------------------------------------------------
// ifetch_buf: 2-entry fetch queue with bypass and flush.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module ifetch_buf
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  output logic         valid_o,
  output fetch_entry_t entry_o,
  output logic [1:0]   count_o
);

  fetch_entry_t head_q, head_d, tail_q, tail_d;
  logic [1:0]   count_q, count_d;

  // An empty queue passes the incoming entry straight to the head outputs.
  assign valid_o = (count_q != 2'd0) | push_i;
  assign entry_o = (count_q != 2'd0) ? head_q : entry_i;
  assign count_o = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push_i && !pop_i) begin
            head_d  = entry_i;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (pop_i && push_i) begin
            head_d = entry_i;
          end else if (pop_i) begin
            count_d = 2'd0;
          end else if (push_i) begin
            tail_d  = entry_i;
            count_d = 2'd2;
          end
        end
        default: begin
          // The issue throttle upstream never pushes into a full queue unpopped.
          if (pop_i) begin
            head_d = tail_q;
            if (push_i) tail_d = entry_i;
            else        count_d = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifetch.sv
// ------------------------------------------------------------------
// ifetch: fetch address generation, in-flight tracking and decode queue.
// Rev 1.0 -- static branch prediction built when IFETCH_BPU_EN is defined.
// ------------------------------------------------------------------
`default_nettype none

module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ram_hold_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  ifetch_if.master    bus
);

  logic [31:0]  fpc_q, fpc_d;
  logic         inflight_q, inflight_d;
  logic         rsp_vld, pop, issue, room, pred_taken, buf_vld;
  logic [1:0]   count;
  logic [31:0]  seq_pc, pc_sel, pc_next;
  fetch_entry_t rsp, head;

  // A redirect kills the response of the read issued on the old path.
  assign rsp_vld = inflight_q & ~redirect_i;

`ifdef IFETCH_BPU_EN
  logic [6:0]  opc;
  logic [31:0] pred_target;

  always_comb begin
    opc         = bus.inst_i[6:0];
    pred_taken  = rsp_vld & ((opc == OPC_JAL) | ((opc == OPC_BRANCH) & bus.inst_i[31]));
    pred_target = bus.pc_i + ((opc == OPC_JAL) ? imm_j(bus.inst_i) : imm_b(bus.inst_i));
    seq_pc      = pred_taken ? pred_target : fpc_q;
  end
`else
  assign pred_taken = 1'b0;
  assign seq_pc     = fpc_q;
`endif

  assign rsp = '{pred: pred_taken, pc: bus.pc_i, inst: bus.inst_i};

  ifetch_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_i),
    .push_i  (rsp_vld),
    .entry_i (rsp),
    .pop_i   (pop),
    .valid_o (buf_vld),
    .entry_o (head),
    .count_o (count)
  );

  assign bus.id_valid_o = buf_vld & ~redirect_i;
  assign bus.id_inst_o  = bus.id_valid_o ? head.inst : 32'h0;
  assign bus.id_pc_o    = bus.id_valid_o ? head.pc   : 32'h0;
  assign bus.id_pred_o  = bus.id_valid_o & head.pred;
  assign pop            = bus.id_valid_o & bus.id_ready_i;

  // Issue only if the word returning next cycle is guaranteed a queue slot.
  always_comb begin
    room   = ({1'b0, count} + {2'b00, inflight_q} - {2'b00, pop}) <= 3'd1;
    pc_sel = seq_pc;
    issue  = rst_n & ~ram_hold_i & room;
    if (redirect_i) begin
      pc_sel = redirect_pc_i;
      issue  = rst_n & ~ram_hold_i;
    end
    pc_next    = {pc_sel[31:2], 2'b00};
    fpc_d      = issue ? pc_next + 32'd4 : pc_next;
    inflight_d = issue;
  end

  assign bus.pc_n_o    = pc_next;
  assign bus.iram_rd_o = issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q      <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

`default_nettype wire
